// File: rtl/tx_frame_sched_if.sv
// tx_frame_sched_if: source-side and MAC-side frame streams plus scheduler status
interface tx_frame_sched_if #(
  parameter int DEVICE_NUM = 4
);
  localparam int PW = $clog2(DEVICE_NUM);
  logic [DEVICE_NUM-1:0]   req;
  logic [8*DEVICE_NUM-1:0] in_data;
  logic [DEVICE_NUM-1:0]   in_valid;
  logic [DEVICE_NUM-1:0]   in_last;
  logic [DEVICE_NUM-1:0]   in_ready;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_ready;
  logic [DEVICE_NUM-1:0]   grant;
  logic [PW-1:0]           port_number;
  logic                    busy;
  logic                    err_len;
  modport master (
    output req, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, grant, port_number, busy, err_len
  );
  modport slave (
    input  req, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, grant, port_number, busy, err_len
  );
endinterface

// File: rtl/tx_frame_sched.sv
// tx_frame_sched: round-robin per-frame scheduler of byte streams onto one MAC TX stream
module tx_frame_sched #(
  parameter int DEVICE_NUM = 4,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1518
) (
  input logic clk,
  input logic rst_n,
  tx_frame_sched_if.slave bus
);
  localparam int PW = $clog2(DEVICE_NUM);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LEN_MAX  = CW'(MAX_LEN);
  localparam logic [CW-1:0] IFG_LOAD = CW'(IFG_CYCLES > 0 ? IFG_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, IFG} state_t;
  localparam state_t END_STATE = (IFG_CYCLES == 0) ? IDLE : IFG;
  state_t state, state_n;
  logic [DEVICE_NUM-1:0] gnt, gnt_n;
  logic [PW-1:0] port, port_n, last, last_n, pick, idx;
  logic [CW-1:0] cnt, cnt_n;
  logic err, err_n, found, sel_valid, sel_last, beat, trunc;
  assign sel_valid       = bus.in_valid[port];
  assign sel_last        = bus.in_last[port];
  assign beat            = state == XFER && sel_valid && bus.out_ready;
  assign trunc           = cnt == LEN_MAX - 1'b1 && !sel_last;
  assign bus.grant       = gnt;
  assign bus.port_number = port;
  assign bus.busy        = state != IDLE;
  assign bus.err_len     = err;
  // round-robin pick: scan from last+1 with wrap, the nearest requester wins
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = DEVICE_NUM; k >= 1; k--) begin
      idx = PW'((int'(last) + k) % DEVICE_NUM);
      if (bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  // next-state logic with the combinational datapath mux on the granted port
  always_comb begin
    state_n       = state;
    gnt_n         = gnt;
    port_n        = port;
    last_n        = last;
    cnt_n         = cnt;
    err_n         = 1'b0;
    bus.out_data  = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.in_ready  = '0;
    case (state)
      IDLE: if (found) begin
        state_n     = XFER;
        gnt_n       = '0;
        gnt_n[pick] = 1'b1;
        port_n      = pick;
        last_n      = pick;
        cnt_n       = '0;
      end
      XFER: begin
        bus.out_data       = bus.in_data[{port, 3'b000} +: 8];
        bus.out_valid      = sel_valid;
        bus.out_last       = sel_last || trunc;
        bus.in_ready[port] = bus.out_ready;
        if (beat) begin
          cnt_n = cnt == LEN_MAX ? cnt : cnt + 1'b1;
          if (trunc) begin
            state_n = DRAIN;
            err_n   = 1'b1;
          end else if (sel_last) begin
            state_n = END_STATE;
            gnt_n   = '0;
            cnt_n   = IFG_LOAD;
          end
        end
      end
      DRAIN: begin
        bus.in_ready[port] = 1'b1;
        if (sel_valid && sel_last) begin
          state_n = END_STATE;
          gnt_n   = '0;
          cnt_n   = IFG_LOAD;
        end
      end
      IFG: if (cnt == '0) state_n = IDLE;
           else cnt_n = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // state and grant registers; after reset the pointer sits on the last port so port 0 leads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      port  <= '0;
      last  <= PW'(DEVICE_NUM - 1);
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      port  <= port_n;
      last  <= last_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end
endmodule

// File: tb/tb_tx_frame_sched.sv
// tb_tx_frame_sched: table-driven frame vectors plus hand sequences for the scheduler
module tb_tx_frame_sched;
  localparam int N = 4;
  typedef struct {
    int port;
    int len;
    bit bp;
    int exp_len;
    int exp_err;
    int exp_drops;
    int exp_span;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_en = '0;
  logic [N-1:0] load = '0;
  logic bp_mode = 1'b0;
  int len [N] = '{default: 1};
  int load_n [N] = '{default: 0};
  int pos [N] = '{default: 0};
  int left [N] = '{default: 0};
  int checks = 0, errors = 0;
  int cyc = 0, beats = 0, fb = 0, last_len = 0, last_beat_cyc = 0, first_beat_cyc = 0;
  int errs = 0, err_cyc = 0, drops = 0, src_end_cyc = 0, busy_falls = 0, fall_cyc = 0;
  int data_bad = 0, mirror_bad = 0, pn_bad = 0;
  logic [N-1:0] first_grant = '0;
  logic prev_busy = 1'b0;
  logic [1:0] cur_port = '0;
  int fports[$];
  int gaps[$];

  tx_frame_sched_if #(.DEVICE_NUM(N)) bus ();
  tx_frame_sched_if #(.DEVICE_NUM(N)) bus0 ();
  tx_frame_sched #(.DEVICE_NUM(N), .IFG_CYCLES(12), .MAX_LEN(1518)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  tx_frame_sched #(.DEVICE_NUM(N), .IFG_CYCLES(0), .MAX_LEN(1518)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;

  // sources: each port streams len-byte frames, byte = {port, position}
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (load[i]) begin
        pos[i]  <= 0;
        left[i] <= load_n[i];
      end else if (left[i] != 0 && bus.in_ready[i]) begin
        if (pos[i] == len[i] - 1) begin
          pos[i]  <= 0;
          left[i] <= left[i] - 1;
        end else pos[i] <= pos[i] + 1;
      end

  always_comb begin
    bus.in_data  = '0;
    bus.in_valid = '0;
    bus.in_last  = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_data[8*i +: 8] = {2'(i), 6'(pos[i])};
      bus.in_valid[i]       = left[i] != 0;
      bus.in_last[i]        = pos[i] == len[i] - 1;
    end
  end
  assign bus.req = req_en & bus.in_valid;

  always @(posedge clk) bus.out_ready <= bp_mode ? ~bus.out_ready : 1'b1;

  // monitor on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      fb = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (fb == 0) begin
          cur_port = bus.out_data[7:6];
          fports.push_back(int'(cur_port));
          gaps.push_back(cyc - last_beat_cyc - 1);
          first_grant = bus.grant;
          first_beat_cyc = cyc;
        end
        if (bus.out_data != {cur_port, 6'(fb)}) data_bad++;
        beats++;
        last_beat_cyc = cyc;
        if (bus.out_last) begin
          last_len = fb + 1;
          fb = 0;
        end else fb++;
      end
      if (|(bus.in_ready & bus.in_valid) && !bus.out_valid) drops++;
      if (|(bus.in_ready & bus.in_valid & bus.in_last)) src_end_cyc = cyc;
      if (bus.err_len) begin
        errs++;
        err_cyc = cyc;
      end
      if (bus.out_valid && bus.in_ready != (bus.out_ready ? bus.grant : 4'b0000)) mirror_bad++;
      if (bus.grant != 4'b0000 && bus.grant != (4'b0001 << bus.port_number)) pn_bad++;
      if (prev_busy && !bus.busy) begin
        busy_falls++;
        fall_cyc = cyc;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic nstep;
    @(negedge clk);
    #1;
  endtask

  task automatic load_src(input int p, input int l, input int n);
    len[p] = l;
    load_n[p] = n;
    load[p] = 1'b1;
    @(posedge clk);
    #1;
    load[p] = 1'b0;
  endtask

  task automatic wait_idle(input int bf0, input string name);
    int k;
    for (k = 0; k < 6000 && busy_falls == bf0; k++) nstep;
    chk({name, " completes"}, int'(busy_falls > bf0), 1);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, " grant"}, bus.grant, 0);
    chk({pfx, " port_number"}, bus.port_number, 0);
    chk({pfx, " busy"}, bus.busy, 0);
    chk({pfx, " err_len"}, bus.err_len, 0);
    chk({pfx, " out_valid"}, bus.out_valid, 0);
    chk({pfx, " out_last"}, bus.out_last, 0);
    chk({pfx, " out_data"}, bus.out_data, 0);
    chk({pfx, " in_ready"}, bus.in_ready, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int bf0, e0, d0, f0, g0, b0, k;
    tbl[0] = '{2, 10,   1'b1, 10,   0, 0,  19};
    tbl[1] = '{3, 1,    1'b0, 1,    0, 0,  1};
    tbl[2] = '{0, 1518, 1'b0, 1518, 0, 0,  1518};
    tbl[3] = '{1, 1600, 1'b0, 1518, 1, 82, 1518};
    tbl[4] = '{2, 1519, 1'b0, 1518, 1, 1,  1518};
    tbl[5] = '{1, 64,   1'b0, 64,   0, 0,  64};
    bus0.req = '0;
    bus0.in_valid = '0;
    bus0.in_last = '0;
    bus0.in_data = '0;
    bus0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    nstep;
    chk_reset("reset");
    rst_n = 1'b1;
    nstep;
    req_en = 4'b0001;
    bf0 = busy_falls;
    b0 = beats;
    load_src(0, 64, 1);
    nstep;
    chk("grant in request cycle", bus.grant, 0);
    nstep;
    chk("grant one cycle later", bus.grant, 1);
    chk("first beat at grant", int'(bus.out_valid && bus.out_ready), 1);
    wait_idle(bf0, "single");
    chk("single beats", beats - b0, 64);
    chk("single out_last beat", last_len, 64);
    chk("single ifg to idle", fall_cyc - src_end_cyc, 13);
    req_en = '0;
    for (int i = 0; i < 6; i++) begin
      bp_mode = tbl[i].bp;
      bf0 = busy_falls;
      e0 = errs;
      d0 = drops;
      f0 = fports.size();
      req_en = 4'(1 << tbl[i].port);
      load_src(tbl[i].port, tbl[i].len, 1);
      wait_idle(bf0, $sformatf("vec%0d", i));
      req_en = '0;
      bp_mode = 1'b0;
      chk($sformatf("vec%0d out_last beat", i), last_len, tbl[i].exp_len);
      chk($sformatf("vec%0d err_len pulses", i), errs - e0, tbl[i].exp_err);
      chk($sformatf("vec%0d dropped bytes", i), drops - d0, tbl[i].exp_drops);
      chk($sformatf("vec%0d ifg to idle", i), fall_cyc - src_end_cyc, 13);
      chk($sformatf("vec%0d port", i), fports.size() > f0 ? fports[f0] : -1, tbl[i].port);
      chk($sformatf("vec%0d grant", i), first_grant, 1 << tbl[i].port);
      chk($sformatf("vec%0d beat span", i), last_beat_cyc - first_beat_cyc + 1, tbl[i].exp_span);
      if (tbl[i].exp_err != 0) chk($sformatf("vec%0d err_len delay", i), err_cyc - last_beat_cyc, 1);
      nstep;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    nstep;
    rst_n = 1'b1;
    f0 = fports.size();
    g0 = gaps.size();
    for (int i = 0; i < N; i++) load_src(i, 4 + i, 3);
    req_en = 4'b1111;
    for (k = 0; k < 3000 && !(fports.size() >= f0 + 12 && !bus.busy && bus.in_valid == 0); k++) nstep;
    chk("rr frame count", fports.size() - f0, 12);
    for (int j = 0; j < 12; j++) begin
      chk($sformatf("rr order %0d", j), fports.size() > f0 + j ? fports[f0 + j] : -1, j % 4);
      if (j > 0) chk($sformatf("rr gap %0d", j), gaps.size() > g0 + j ? gaps[g0 + j] : -1, 13);
    end
    req_en = 4'b0001;
    b0 = beats;
    load_src(0, 64, 1);
    for (k = 0; k < 200 && beats - b0 < 19; k++) nstep;
    @(posedge clk);
    #2;
    chk("beat 20 in flight", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("async reset");
    req_en = 4'b0100;
    load_src(0, 0, 0);
    nstep;
    rst_n = 1'b1;
    bf0 = busy_falls;
    load_src(2, 5, 1);
    for (k = 0; k < 20 && bus.grant == 0; k++) nstep;
    chk("post-reset grant", bus.grant, 4'b0100);
    chk("post-reset port_number", bus.port_number, 2);
    wait_idle(bf0, "post-reset");
    chk("post-reset frame length", last_len, 5);
    req_en = '0;
    nstep;
    bus0.in_valid = 4'b0011;
    bus0.in_last = 4'b0011;
    bus0.req = 4'b0011;
    for (k = 0; k < 10 && !bus0.out_valid; k++) nstep;
    chk("ifg0 first beat", int'(bus0.out_valid), 1);
    chk("ifg0 first grant", bus0.grant, 1);
    chk("ifg0 first out_last", int'(bus0.out_last), 1);
    for (int j = 1; j <= 6; j++) begin
      nstep;
      chk($sformatf("ifg0 valid +%0d", j), int'(bus0.out_valid), int'(j % 2 == 0));
      if (j % 2 == 0) chk($sformatf("ifg0 grant +%0d", j), bus0.grant, (j % 4 == 2) ? 2 : 1);
    end
    bus0.req = '0;
    chk("frame data errors", data_bad, 0);
    chk("in_ready mirror errors", mirror_bad, 0);
    chk("port_number vs grant errors", pn_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
